// File: rtl/rcc_domain_clk_gate_ctrl.sv
// Clock-gating controller for the RCC CPU/bus clock tree: per-CPU sleep gating and
// per-domain drain/stop handshake with timeout and wake-up settle delay.
module rcc_domain_clk_gate_ctrl #(
  parameter int NUM_CPU  = 2,
  parameter int NUM_DOM  = 3,
  parameter int DRAIN_TO = 16,
  parameter int WAKE_DLY = 4,
  parameter int CNT_W    = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [NUM_CPU-1:0]         cpu_sleep,
  input  logic [NUM_CPU-1:0]         cpu_deepsleep,
  input  logic [NUM_CPU*NUM_DOM-1:0] cpu_alloc,
  input  logic [NUM_DOM-1:0]         dom_keep,
  input  logic [NUM_DOM-1:0]         dom_stop_ack,
  output logic [NUM_CPU-1:0]         cpu_clk_en,
  output logic [NUM_CPU-1:0]         cpu_fclk_en,
  output logic [NUM_CPU-1:0]         cpu_systick_en,
  output logic [NUM_DOM-1:0]         dom_clk_en,
  output logic [NUM_DOM-1:0]         dom_stop_req,
  output logic [NUM_DOM-1:0]         dom_rdy,
  output logic [NUM_DOM-1:0]         dom_timeout
);

  typedef enum logic [1:0] {CPU_RUN, CPU_SLEEP, CPU_DSLEEP, CPU_WAKE} cpu_state_t;
  typedef enum logic [1:0] {DOM_ON, DOM_DRAIN, DOM_OFF, DOM_WAKE} dom_state_t;

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TO - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  cpu_state_t       cpu_st  [NUM_CPU];
  dom_state_t       dom_st  [NUM_DOM];
  logic [CNT_W-1:0] dom_cnt [NUM_DOM];
  logic [NUM_DOM-1:0] timeout_q;
  logic [NUM_DOM-1:0] need;
  logic [NUM_CPU-1:0] alloc_rdy;

  always_comb begin
    need = dom_keep;
    for (int d = 0; d < NUM_DOM; d++)
      for (int c = 0; c < NUM_CPU; c++)
        if (cpu_alloc[c*NUM_DOM+d] && !cpu_deepsleep[c]) need[d] = 1'b1;
  end

  // A waking CPU may run once every domain it uses reports ready.
  always_comb begin
    alloc_rdy = '1;
    for (int c = 0; c < NUM_CPU; c++)
      for (int d = 0; d < NUM_DOM; d++)
        if (cpu_alloc[c*NUM_DOM+d] && !dom_rdy[d]) alloc_rdy[c] = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int c = 0; c < NUM_CPU; c++) cpu_st[c] <= CPU_RUN;
    end else begin
      for (int c = 0; c < NUM_CPU; c++) begin
        case (cpu_st[c])
          CPU_RUN:
            if (cpu_deepsleep[c]) cpu_st[c] <= CPU_DSLEEP;
            else if (cpu_sleep[c]) cpu_st[c] <= CPU_SLEEP;
          CPU_SLEEP:
            if (cpu_deepsleep[c]) cpu_st[c] <= CPU_DSLEEP;
            else if (!cpu_sleep[c]) cpu_st[c] <= CPU_RUN;
          CPU_DSLEEP:
            if (!cpu_deepsleep[c]) cpu_st[c] <= CPU_WAKE;
          default:
            if (cpu_deepsleep[c]) cpu_st[c] <= CPU_DSLEEP;
            else if (alloc_rdy[c]) cpu_st[c] <= CPU_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      timeout_q <= '0;
      for (int d = 0; d < NUM_DOM; d++) begin
        dom_st[d]  <= DOM_ON;
        dom_cnt[d] <= '0;
      end
    end else begin
      timeout_q <= '0;
      for (int d = 0; d < NUM_DOM; d++) begin
        case (dom_st[d])
          DOM_ON:
            if (!need[d]) begin
              dom_st[d]  <= DOM_DRAIN;
              dom_cnt[d] <= '0;
            end
          // Ack takes priority over the timeout when both land together.
          DOM_DRAIN:
            if (need[d]) dom_st[d] <= DOM_ON;
            else if (dom_stop_ack[d]) dom_st[d] <= DOM_OFF;
            else if (dom_cnt[d] == DRAIN_LAST) begin
              dom_st[d]    <= DOM_OFF;
              timeout_q[d] <= 1'b1;
            end else if (dom_cnt[d] != CNT_MAX) dom_cnt[d] <= dom_cnt[d] + 1'b1;
          DOM_OFF:
            if (need[d]) begin
              dom_st[d]  <= DOM_WAKE;
              dom_cnt[d] <= '0;
            end
          default:
            if (!need[d]) begin
              dom_st[d]  <= DOM_DRAIN;
              dom_cnt[d] <= '0;
            end else if (dom_cnt[d] == WAKE_LAST) dom_st[d] <= DOM_ON;
            else if (dom_cnt[d] != CNT_MAX) dom_cnt[d] <= dom_cnt[d] + 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CPU; c++) begin
      cpu_clk_en[c]     = (cpu_st[c] == CPU_RUN);
      cpu_fclk_en[c]    = (cpu_st[c] != CPU_DSLEEP);
      cpu_systick_en[c] = (cpu_st[c] != CPU_DSLEEP);
    end
    for (int d = 0; d < NUM_DOM; d++) begin
      dom_clk_en[d]   = (dom_st[d] != DOM_OFF);
      dom_rdy[d]      = (dom_st[d] == DOM_ON);
      dom_stop_req[d] = (dom_st[d] == DOM_DRAIN) || (dom_st[d] == DOM_OFF);
    end
  end

  assign dom_timeout = timeout_q;

endmodule

// File: tb/tb_rcc_domain_clk_gate_ctrl.sv
// Randomized bench for rcc_domain_clk_gate_ctrl against a per-cycle behavioural model.
module tb_rcc_domain_clk_gate_ctrl;
  localparam int NC = 2;
  localparam int ND = 3;
  localparam int DT = 16;
  localparam int WD = 4;
  localparam int NCYC = 4000;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic [NC-1:0]    cpu_sleep, cpu_deepsleep;
  logic [NC*ND-1:0] cpu_alloc;
  logic [ND-1:0]    dom_keep, dom_stop_ack;
  logic [NC-1:0]    cpu_clk_en, cpu_fclk_en, cpu_systick_en;
  logic [ND-1:0]    dom_clk_en, dom_stop_req, dom_rdy, dom_timeout;

  rcc_domain_clk_gate_ctrl #(
    .NUM_CPU(NC), .NUM_DOM(ND), .DRAIN_TO(DT), .WAKE_DLY(WD), .CNT_W(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cpu_sleep(cpu_sleep), .cpu_deepsleep(cpu_deepsleep), .cpu_alloc(cpu_alloc),
    .dom_keep(dom_keep), .dom_stop_ack(dom_stop_ack),
    .cpu_clk_en(cpu_clk_en), .cpu_fclk_en(cpu_fclk_en), .cpu_systick_en(cpu_systick_en),
    .dom_clk_en(dom_clk_en), .dom_stop_req(dom_stop_req), .dom_rdy(dom_rdy),
    .dom_timeout(dom_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: named phases plus "edges spent in this phase".
  localparam int M_RUN = 0, M_SLEEP = 1, M_DEEP = 2, M_CWAKE = 3;
  localparam int M_ON = 0, M_DRAIN = 1, M_OFF = 2, M_DWAKE = 3;
  int m_cpu [NC];
  int m_dom [ND];
  int m_age [ND];
  bit m_to  [ND];

  always @(posedge sys_clk or posedge sys_rst) begin
    int  nc [NC];
    int  nd [ND];
    int  na [ND];
    bit  nt [ND];
    bit  nd_need;
    bit  ready;
    if (sys_rst) begin
      for (int c = 0; c < NC; c++) m_cpu[c] <= M_RUN;
      for (int d = 0; d < ND; d++) begin
        m_dom[d] <= M_ON; m_age[d] <= 0; m_to[d] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        ready = 1'b1;
        for (int d = 0; d < ND; d++)
          if (cpu_alloc[c*ND+d] && m_dom[d] != M_ON) ready = 1'b0;
        nc[c] = m_cpu[c];
        if (cpu_deepsleep[c] && m_cpu[c] != M_DEEP) nc[c] = M_DEEP;
        else if (m_cpu[c] == M_RUN && cpu_sleep[c]) nc[c] = M_SLEEP;
        else if (m_cpu[c] == M_SLEEP && !cpu_sleep[c]) nc[c] = M_RUN;
        else if (m_cpu[c] == M_DEEP && !cpu_deepsleep[c]) nc[c] = M_CWAKE;
        else if (m_cpu[c] == M_CWAKE && ready) nc[c] = M_RUN;
      end
      for (int d = 0; d < ND; d++) begin
        nd_need = dom_keep[d];
        for (int c = 0; c < NC; c++)
          if (cpu_alloc[c*ND+d] && !cpu_deepsleep[c]) nd_need = 1'b1;
        nd[d] = m_dom[d]; na[d] = m_age[d] + 1; nt[d] = 1'b0;
        if (m_dom[d] == M_ON && !nd_need) begin nd[d] = M_DRAIN; na[d] = 0; end
        else if (m_dom[d] == M_DRAIN) begin
          if (nd_need) nd[d] = M_ON;
          else if (dom_stop_ack[d]) nd[d] = M_OFF;
          else if (m_age[d] + 1 == DT) begin nd[d] = M_OFF; nt[d] = 1'b1; end
        end
        else if (m_dom[d] == M_OFF && nd_need) begin nd[d] = M_DWAKE; na[d] = 0; end
        else if (m_dom[d] == M_DWAKE) begin
          if (!nd_need) begin nd[d] = M_DRAIN; na[d] = 0; end
          else if (m_age[d] + 1 == WD) nd[d] = M_ON;
        end
      end
      for (int c = 0; c < NC; c++) m_cpu[c] <= nc[c];
      for (int d = 0; d < ND; d++) begin
        m_dom[d] <= nd[d]; m_age[d] <= na[d]; m_to[d] <= nt[d];
      end
    end
  end

  task automatic compare_all();
    logic [NC-1:0] e_clk, e_fclk;
    logic [ND-1:0] e_den, e_req, e_rdy, e_to;
    for (int c = 0; c < NC; c++) begin
      e_clk[c]  = (m_cpu[c] == M_RUN);
      e_fclk[c] = (m_cpu[c] != M_DEEP);
    end
    for (int d = 0; d < ND; d++) begin
      e_den[d] = (m_dom[d] != M_OFF);
      e_req[d] = (m_dom[d] == M_DRAIN) || (m_dom[d] == M_OFF);
      e_rdy[d] = (m_dom[d] == M_ON);
      e_to[d]  = m_to[d];
    end
    check("cpu_clk_en", 32'(cpu_clk_en), 32'(e_clk));
    check("cpu_fclk_en", 32'(cpu_fclk_en), 32'(e_fclk));
    check("cpu_systick_en", 32'(cpu_systick_en), 32'(e_fclk));
    check("dom_clk_en", 32'(dom_clk_en), 32'(e_den));
    check("dom_stop_req", 32'(dom_stop_req), 32'(e_req));
    check("dom_rdy", 32'(dom_rdy), 32'(e_rdy));
    check("dom_timeout", 32'(dom_timeout), 32'(e_to));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_clk_en"}, 32'(cpu_clk_en), 32'({NC{1'b1}}));
    check({tag, "_cpu_fclk_en"}, 32'(cpu_fclk_en), 32'({NC{1'b1}}));
    check({tag, "_cpu_systick_en"}, 32'(cpu_systick_en), 32'({NC{1'b1}}));
    check({tag, "_dom_clk_en"}, 32'(dom_clk_en), 32'({ND{1'b1}}));
    check({tag, "_dom_rdy"}, 32'(dom_rdy), 32'({ND{1'b1}}));
    check({tag, "_dom_stop_req"}, 32'(dom_stop_req), 32'(0));
    check({tag, "_dom_timeout"}, 32'(dom_timeout), 32'(0));
  endtask

  initial begin
    int mode;
    sys_rst = 1'b1;
    cpu_sleep = '0; cpu_deepsleep = '0; cpu_alloc = '1;
    dom_keep = '0; dom_stop_ack = '0;
    #2 check_reset_vals("reset");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge sys_clk);
      compare_all();
      mode = (cyc / 100) % 4;
      if (cyc % 100 == 0 && (mode == 1 || mode == 2)) begin
        cpu_deepsleep = '1; dom_keep = '0;
      end
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 7) == 0)  cpu_sleep[c] = ~cpu_sleep[c];
        if ($urandom_range(0, 29) == 0) cpu_deepsleep[c] = ~cpu_deepsleep[c];
      end
      for (int d = 0; d < ND; d++) begin
        if ($urandom_range(0, 39) == 0) dom_keep[d] = ~dom_keep[d];
        dom_stop_ack[d] = (mode == 1) ? 1'b0 : ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 79) == 0) cpu_alloc = (NC*ND)'($urandom);
      if (cyc == 1500 || cyc == 3100) begin
        #2 sys_rst = 1'b1;
        #1 check_reset_vals("async_reset");
        @(negedge sys_clk);
        compare_all();
        sys_rst = 1'b0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
